// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 16-bit memory between the fetch and data ports.
// Each grant runs a setup / chip-select strobe / wait / capture sequence, then acks the winner.
module mem_port_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    output logic        f_ack,
    output logic [15:0] f_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] d_rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        mem_cs,
    input  logic [15:0] mem_data_out,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        WAIT,
        DONE
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t     state;
    logic [3:0] wait_cnt;
    logic       last_grant;
    logic       cur_port;
    logic       cur_we;
    logic       grant_d;
    logic       grant_f;

    // Port encoding: 0 = fetch, 1 = data. On a tie the port not served last wins.
    always_comb begin
        grant_d = d_req && (!f_req || !last_grant);
        grant_f = f_req && !grant_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= 4'd0;
            last_grant  <= 1'b0;
            cur_port    <= 1'b0;
            cur_we      <= 1'b0;
            f_ack       <= 1'b0;
            d_ack       <= 1'b0;
            f_rdata     <= 16'h0000;
            d_rdata     <= 16'h0000;
            mem_addr    <= 16'h0000;
            mem_data_in <= 16'h0000;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_cs      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d || grant_f) begin
                        cur_port   <= grant_d;
                        cur_we     <= grant_d && d_we;
                        last_grant <= grant_d;
                        mem_addr   <= grant_d ? d_addr : f_addr;
                        if (grant_d) begin
                            mem_data_in <= d_wdata;
                        end
                        mem_rd     <= !(grant_d && d_we);
                        mem_wr     <= grant_d && d_we;
                        busy       <= 1'b1;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    mem_cs <= 1'b1;
                    state  <= STROBE;
                end
                STROBE: begin
                    mem_cs   <= 1'b0;
                    wait_cnt <= WAIT_LOAD;
                    state    <= WAIT;
                end
                WAIT: begin
                    // Read data is sampled on the edge that leaves WAIT; writes leave rdata alone.
                    if (wait_cnt == 4'd0) begin
                        if (!cur_we) begin
                            if (cur_port) begin
                                d_rdata <= mem_data_out;
                            end else begin
                                f_rdata <= mem_data_out;
                            end
                        end
                        if (cur_port) begin
                            d_ack <= 1'b1;
                        end else begin
                            f_ack <= 1'b1;
                        end
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        state  <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DONE: begin
                    f_ack <= 1'b0;
                    d_ack <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level model predicts grant order,
// ack timing, memory strobes and returned data for the default and a 3-wait-cycle instance.
module tb_mem_port_arbiter;

    localparam int W   = 1;
    localparam int LAT = 3 + W;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, d_req, d_we;
    logic [15:0] f_addr, d_addr, d_wdata;
    logic        f_ack, d_ack, mem_rd, mem_wr, mem_cs, busy;
    logic [15:0] f_rdata, d_rdata, mem_addr, mem_data_in, mem_data_out;

    logic        f_req_3, d_req_3, d_we_3;
    logic [15:0] f_addr_3, d_addr_3, d_wdata_3;
    logic        f_ack_3, d_ack_3, mem_rd_3, mem_wr_3, mem_cs_3, busy_3;
    logic [15:0] f_rdata_3, d_rdata_3, mem_addr_3, mem_data_in_3, mem_data_out_3;

    logic [15:0] mem     [0:63];
    logic [15:0] mem_3   [0:63];
    logic [15:0] ref_mem [0:63];

    int          checks = 0;
    int          fails  = 0;
    bit          last_was_data;
    logic [15:0] exp_f_rdata, exp_d_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .mem_cs(mem_cs), .mem_data_out(mem_data_out), .busy(busy)
    );

    mem_port_arbiter #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst),
        .f_req(f_req_3), .f_addr(f_addr_3), .f_ack(f_ack_3), .f_rdata(f_rdata_3),
        .d_req(d_req_3), .d_we(d_we_3), .d_addr(d_addr_3), .d_wdata(d_wdata_3),
        .d_ack(d_ack_3), .d_rdata(d_rdata_3),
        .mem_addr(mem_addr_3), .mem_data_in(mem_data_in_3), .mem_rd(mem_rd_3),
        .mem_wr(mem_wr_3), .mem_cs(mem_cs_3), .mem_data_out(mem_data_out_3), .busy(busy_3)
    );

    function automatic logic [15:0] init_word(input int i);
        return 16'(i * 32'h0731 + 32'h1357);
    endfunction

    // Memory blocks: act only on the cs strobe; read data appears after the strobe edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            mem_data_out <= 16'h0000;
        end else if (mem_cs) begin
            if (mem_wr) mem[mem_addr[5:0]] <= mem_data_in;
            if (mem_rd) mem_data_out <= mem[mem_addr[5:0]];
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem_3[i] <= init_word(i);
            mem_data_out_3 <= 16'h0000;
        end else if (mem_cs_3) begin
            if (mem_wr_3) mem_3[mem_addr_3[5:0]] <= mem_data_in_3;
            if (mem_rd_3) mem_data_out_3 <= mem_3[mem_addr_3[5:0]];
        end
    end

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit fr, input logic [15:0] fa, input bit dr, input bit dwe,
                                 input logic [15:0] da, input logic [15:0] dwd);
        f_req   = fr;
        f_addr  = fa;
        d_req   = dr;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dwd;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        last_was_data = 1'b0;
        exp_f_rdata   = 16'h0000;
        exp_d_rdata   = 16'h0000;
    endtask

    // Issues one or two requests at a negedge and checks every following cycle against
    // the timeline derived from the arbitration rule and the 3+W latency.
    task automatic run_txn(input bit fr, input logic [15:0] fa, input bit dr, input bit dwe,
                           input logic [15:0] da, input logic [15:0] dwd, input bit scramble);
        int s_f, s_d, last_k;
        bit d_first, act_f, act_d;
        s_f = -100;
        s_d = -100;
        d_first = dr && (!fr || !last_was_data);
        if (fr && dr) begin
            if (d_first) begin
                s_d = 0;
                s_f = LAT + 1;
            end else begin
                s_f = 0;
                s_d = LAT + 1;
            end
            last_was_data = !d_first;
        end else if (dr) begin
            s_d = 0;
            last_was_data = 1'b1;
        end else begin
            s_f = 0;
            last_was_data = 1'b0;
        end
        last_k = ((fr && dr) ? 2 * LAT + 1 : LAT) + 1;
        applyStimulus(fr, fa, dr, dwe, da, dwd);
        for (int k = 1; k <= last_k; k++) begin
            @(negedge clk);
            act_f = fr && k > s_f && k <= s_f + LAT;
            act_d = dr && k > s_d && k <= s_d + LAT;
            if (k == s_f + LAT) exp_f_rdata = ref_mem[fa[5:0]];
            if (k == s_d + LAT) begin
                if (dwe) ref_mem[da[5:0]] = dwd;
                else     exp_d_rdata = ref_mem[da[5:0]];
            end
            checkOutput("f_ack", f_ack, k == s_f + LAT);
            checkOutput("d_ack", d_ack, k == s_d + LAT);
            checkOutput("busy", busy, act_f || act_d);
            checkOutput("mem_cs", mem_cs, (fr && k == s_f + 2) || (dr && k == s_d + 2));
            checkOutput("mem_rd", mem_rd, (act_f && k < s_f + LAT) || (act_d && !dwe && k < s_d + LAT));
            checkOutput("mem_wr", mem_wr, act_d && dwe && k < s_d + LAT);
            if (act_f) checkOutput("mem_addr_f", mem_addr, fa);
            if (act_d) begin
                checkOutput("mem_addr_d", mem_addr, da);
                checkOutput("mem_data_in", mem_data_in, dwd);
            end
            checkOutput("f_rdata", f_rdata, exp_f_rdata);
            checkOutput("d_rdata", d_rdata, exp_d_rdata);
            if (k == s_f + LAT) f_req = 1'b0;
            if (k == s_d + LAT) d_req = 1'b0;
            // The winner disturbs its own inputs during STROBE; the access in flight must not notice.
            if (scramble && k == 2) begin
                if (s_f == 0) begin
                    f_addr = fa ^ 16'h000B;
                    f_req  = 1'b0;
                end else begin
                    d_addr  = da ^ 16'h000B;
                    d_wdata = ~dwd;
                    d_we    = !dwe;
                    d_req   = 1'b0;
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sel;
        rst = 1'b1;
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        f_req_3 = 1'b0; f_addr_3 = 16'h0; d_req_3 = 1'b0;
        d_we_3 = 1'b0; d_addr_3 = 16'h0; d_wdata_3 = 16'h0;
        model_reset();
        repeat (3) @(negedge clk);

        checkOutput("rst_f_ack", f_ack, 1'b0);
        checkOutput("rst_d_ack", d_ack, 1'b0);
        checkOutput("rst_f_rdata", f_rdata, 16'h0000);
        checkOutput("rst_d_rdata", d_rdata, 16'h0000);
        checkOutput("rst_mem_addr", mem_addr, 16'h0000);
        checkOutput("rst_mem_data_in", mem_data_in, 16'h0000);
        checkOutput("rst_mem_rd", mem_rd, 1'b0);
        checkOutput("rst_mem_wr", mem_wr, 1'b0);
        checkOutput("rst_mem_cs", mem_cs, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Tie straight after reset: data first, then alternating D, F, D, F.
        run_txn(1'b1, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
        run_txn(1'b1, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);

        run_txn(1'b0, 16'h0000, 1'b1, 1'b1, 16'h000C, 16'h0021, 1'b0);
        run_txn(1'b0, 16'h0000, 1'b1, 1'b0, 16'h000C, 16'h0000, 1'b0);
        checkOutput("write_then_read", d_rdata, 16'h0021);

        run_txn(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0);
        run_txn(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);
        run_txn(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'h5555, 1'b0);
        checkOutput("rdata_kept_on_write", d_rdata, 16'h1234);

        run_txn(1'b1, 16'h0002, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        checkOutput("addr_change_data", f_rdata, init_word(2));

        // Reset during WAIT of a data read aborts it without an ack.
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0007, 16'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_d_ack", d_ack, 1'b0);
        checkOutput("abort_f_ack", f_ack, 1'b0);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_mem_cs", mem_cs, 1'b0);
        checkOutput("abort_mem_rd", mem_rd, 1'b0);
        checkOutput("abort_mem_wr", mem_wr, 1'b0);
        checkOutput("abort_mem_addr", mem_addr, 16'h0000);
        checkOutput("abort_mem_data_in", mem_data_in, 16'h0000);
        checkOutput("abort_d_rdata", d_rdata, 16'h0000);
        checkOutput("abort_f_rdata", f_rdata, 16'h0000);
        rst   = 1'b0;
        d_req = 1'b0;
        model_reset();
        @(negedge clk);
        run_txn(1'b1, 16'h0003, 1'b1, 1'b0, 16'h0007, 16'h0000, 1'b0);

        repeat (40) begin
            sel = $urandom_range(1, 3);
            run_txn(sel[0], 16'($urandom_range(0, 63)), sel[1], 1'($urandom_range(0, 1)),
                    16'($urandom_range(0, 63)), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        // Three wait cycles: 6-cycle latency, strobe still in the second cycle only.
        d_req_3 = 1'b1; d_we_3 = 1'b1; d_addr_3 = 16'h0005; d_wdata_3 = 16'hBEEF;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checkOutput("w3_d_ack", d_ack_3, k == 6);
            checkOutput("w3_wr_cs", mem_cs_3, k == 2);
            if (k == 6) d_req_3 = 1'b0;
        end
        f_req_3 = 1'b1; f_addr_3 = 16'h0005;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checkOutput("w3_f_ack", f_ack_3, k == 6);
            checkOutput("w3_rd_cs", mem_cs_3, k == 2);
            checkOutput("w3_busy", busy_3, k >= 1 && k <= 6);
            if (k == 6) begin
                checkOutput("w3_f_rdata", f_rdata_3, 16'hBEEF);
                f_req_3 = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencing arbiter that shares the single 16-bit memory block (`addr`, `data_in`, `rd`, `wr`, `cs`, `data_out`) between the CPU instruction-fetch port and the CPU data port. It serialises the two requesters round-robin and turns each granted request into the memory's setup / chip-select-strobe / wait / capture sequence. It then returns read data and a one-cycle acknowledge to the winning requester. It sits between the core's fetch and load/store units and the memory instance.

## Interface
- `WAIT_CYCLES`, default 1: cycles between the `cs` strobe and read-data capture; legal values are 1..15.

- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `f_req` in 1: fetch read request; held until `f_ack`.
- `f_addr` in 16: fetch address.
- `f_ack` out 1: one-cycle fetch completion pulse.
- `f_rdata` out 16: fetch read data; valid with `f_ack`, held until the next fetch capture.
- `d_req` in 1: data request; held until `d_ack`.
- `d_we` in 1: 1 selects a write, 0 selects a read.
- `d_addr` in 16: data address.
- `d_wdata` in 16: write data.
- `d_ack` out 1: one-cycle data completion pulse.
- `d_rdata` out 16: data read result; valid with `d_ack` on reads, held otherwise.
- `mem_addr` out 16: to memory `addr`.
- `mem_data_in` out 16: to memory `data_in`.
- `mem_rd` out 1: to memory `rd`.
- `mem_wr` out 1: to memory `wr`.
- `mem_cs` out 1: to memory `cs`; a single-cycle strobe per access.
- `mem_data_out` in 16: from memory `data_out`.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, SETUP, STROBE, WAIT, DONE. All outputs are registered.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If one request is high, grant it.
  - If both are high, grant the port that was not granted last (`last_grant`; reset value = fetch, so data wins the first tie).
  - On a grant, latch the port ID, address, direction and write data, update `last_grant`, and go to SETUP.
  - Fetch is always a read.
- SETUP (1 cycle):
  - `mem_addr`/`mem_data_in` carry the latched values.
  - `mem_rd` = !we and `mem_wr` = we, asserted from this cycle onward.
  - `mem_cs` = 0.
- STROBE (1 cycle): `mem_cs` = 1; address, data and rd/wr unchanged.
- WAIT:
  - `mem_cs` = 0.
  - A 4-bit counter loads `WAIT_CYCLES-1` on entry and decrements each cycle; exit to DONE when it reads 0.
  - On the exit edge, a read samples `mem_data_out` into the granted port's rdata register.
- DONE (1 cycle):
  - The granted port's ack = 1.
  - `mem_rd` = `mem_wr` = 0.
  - Next state is IDLE.
- `mem_addr` and `mem_data_in` retain their last values outside a transaction.
- Latched transaction values are used throughout. A requester that changes addr/data or drops req mid-transaction does not affect the access in flight; it still completes and acks.
- Write transactions never modify `d_rdata` or `f_rdata`.
- The non-granted request waits; it is never dropped.
- Reset in any state:
  - Next state is IDLE; the counter clears; `last_grant` = fetch.
  - An access in flight is aborted with no ack.

## Timing
- Reset values: all outputs 0; `f_rdata` = `d_rdata` = 0x0000; `mem_addr` = `mem_data_in` = 0x0000; `busy` = 0.
- Timing is relative to request sampled high at edge E (in IDLE):
  - SETUP in cycle E+1.
  - `mem_cs` high in cycle E+2 only.
  - WAIT in cycles E+3 .. E+2+`WAIT_CYCLES`.
  - Data captured at the end of the last WAIT cycle.
  - Ack and valid rdata in cycle E+3+`WAIT_CYCLES`.
- Request-to-ack latency is 3+`WAIT_CYCLES` cycles; with the default, that is 4.
- Throughput is one access per 4+`WAIT_CYCLES` cycles, because one IDLE cycle is always inserted after DONE.
- A requester must deassert req in the cycle following its ack. A req still high in the IDLE cycle is treated as a new request; this is how back-to-back accesses are issued.
- Only one ack is ever high in a given cycle, and at most one `mem_cs` pulse occurs per transaction.

## Test plan
- Data write then read: `d_we`=1, `d_addr`=0x000C, `d_wdata`=0x0021. Expect a single `mem_cs` pulse with `mem_wr`=1 and `mem_addr`=0x000C, then `d_ack` 4 cycles after the request. Follow with a read of 0x000C: expect `d_rdata`=0x0021 when `d_ack` is high.
- Simultaneous requests after reset: `f_req` and `d_req` both high, `f_addr`=0x0000, `d_addr`=0x0010. Expect the data port served first (`d_ack`) and the fetch served next with no lost request. Then hold both for 4 transactions: expect acks alternating D, F, D, F.
- `WAIT_CYCLES`=3: fetch 0x0005 from memory preloaded with 0xBEEF. Expect `f_ack` 6 cycles after `f_req` and `f_rdata`=0xBEEF.
- Address changed mid-access: change `f_addr` from 0x0002 to 0x0009 during STROBE. Expect `mem_addr` to stay 0x0002 and the data captured to come from 0x0002.
- Reset mid-access: assert `rst` during WAIT of a data read. Expect no `d_ack`, `busy`=0 and all outputs 0 the next cycle. A subsequent request must complete normally with 4-cycle latency.
- Write does not touch rdata: `d_rdata`=0x1234 from a prior read, then a write of 0x5555. Expect `d_rdata` to remain 0x1234.
